// File: rtl/tuner_ctrl_search.sv
// Ring-tuner peak search: sweeps DAC codes start..end by step through the arbiter
// handshakes and keeps the strongest committed power sample and its code.
module tuner_ctrl_search #(
   parameter int DAC_WIDTH = 8,
   parameter int ADC_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_search_start,
   input  logic                 i_search_abort,
   input  logic [DAC_WIDTH-1:0] i_cfg_code_start,
   input  logic [DAC_WIDTH-1:0] i_cfg_code_end,
   input  logic [DAC_WIDTH-1:0] i_cfg_code_step,
   output logic                 o_ctrl_active,
   output logic                 o_ctrl_refresh,
   output logic                 o_tune_val,
   input  logic                 i_tune_rdy,
   output logic [DAC_WIDTH-1:0] o_ring_tune,
   input  logic                 i_commit_val,
   output logic                 o_commit_rdy,
   input  logic [ADC_WIDTH-1:0] i_pwr_commit,
   input  logic [DAC_WIDTH-1:0] i_ring_tune_commit,
   output logic                 o_search_done,
   output logic [ADC_WIDTH-1:0] o_peak_pwr,
   output logic [DAC_WIDTH-1:0] o_peak_code,
   output logic [DAC_WIDTH:0]   o_sample_cnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_TUNE   = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [DAC_WIDTH-1:0] STEP_ONE = {{(DAC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DAC_WIDTH:0]   CNT_ONE  = {{DAC_WIDTH{1'b0}}, 1'b1};

   logic [2:0]           state_q, state_d;
   logic [DAC_WIDTH-1:0] code_q, code_d;
   logic [DAC_WIDTH-1:0] start_q, start_d;
   logic [DAC_WIDTH-1:0] end_q, end_d;
   logic [DAC_WIDTH-1:0] step_q, step_d;
   logic [ADC_WIDTH-1:0] peak_pwr_q, peak_pwr_d;
   logic [DAC_WIDTH-1:0] peak_code_q, peak_code_d;
   logic                 valid_q, valid_d;
   logic [DAC_WIDTH:0]   cnt_q, cnt_d;
   logic [DAC_WIDTH:0]   next_sum;

   // One extra bit so a step past the top code is seen as beyond the end.
   assign next_sum = {1'b0, code_q} + {1'b0, step_q};

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      start_d     = start_q;
      end_d       = end_q;
      step_d      = step_q;
      peak_pwr_d  = peak_pwr_q;
      peak_code_d = peak_code_q;
      valid_d     = valid_q;
      cnt_d       = cnt_q;
      if (i_search_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (i_search_start) begin
                  state_d = S_INIT;
                  start_d = i_cfg_code_start;
                  end_d   = i_cfg_code_end;
                  step_d  = (i_cfg_code_step == '0) ? STEP_ONE : i_cfg_code_step;
               end
            end
            S_INIT: begin
               state_d     = S_TUNE;
               code_d      = start_q;
               peak_pwr_d  = '0;
               peak_code_d = '0;
               valid_d     = 1'b0;
               cnt_d       = '0;
            end
            S_TUNE: begin
               if (i_tune_rdy) state_d = S_COMMIT;
            end
            S_COMMIT: begin
               if (i_commit_val) begin
                  cnt_d = cnt_q + CNT_ONE;
                  // Strictly greater: on ties the earlier code wins.
                  if (!valid_q || (i_pwr_commit > peak_pwr_q)) begin
                     peak_pwr_d  = i_pwr_commit;
                     peak_code_d = i_ring_tune_commit;
                     valid_d     = 1'b1;
                  end
                  if (next_sum > {1'b0, end_q}) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_TUNE;
                     code_d  = next_sum[DAC_WIDTH-1:0];
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         code_q      <= '0;
         start_q     <= '0;
         end_q       <= '0;
         step_q      <= '0;
         peak_pwr_q  <= '0;
         peak_code_q <= '0;
         valid_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         start_q     <= start_d;
         end_q       <= end_d;
         step_q      <= step_d;
         peak_pwr_q  <= peak_pwr_d;
         peak_code_q <= peak_code_d;
         valid_q     <= valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign o_ctrl_active  = (state_q == S_INIT) || (state_q == S_TUNE) || (state_q == S_COMMIT);
   assign o_ctrl_refresh = (state_q == S_INIT);
   assign o_tune_val     = (state_q == S_TUNE);
   assign o_commit_rdy   = (state_q == S_COMMIT);
   assign o_search_done  = (state_q == S_DONE);
   assign o_ring_tune    = code_q;
   assign o_peak_pwr     = peak_pwr_q;
   assign o_peak_code    = peak_code_q;
   assign o_sample_cnt   = cnt_q;

endmodule

// File: tb/tb_tuner_ctrl_search.sv
// Directed bench for tuner_ctrl_search with a simple always-ready arbiter stand-in.
module tb_tuner_ctrl_search;

   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_search_start = 1'b0;
   logic       i_search_abort = 1'b0;
   logic [7:0] i_cfg_code_start = '0;
   logic [7:0] i_cfg_code_end = '0;
   logic [7:0] i_cfg_code_step = '0;
   logic       o_ctrl_active, o_ctrl_refresh, o_tune_val, o_commit_rdy, o_search_done;
   logic       i_tune_rdy, i_commit_val;
   logic [7:0] o_ring_tune, i_pwr_commit, i_ring_tune_commit, o_peak_pwr, o_peak_code;
   logic [8:0] o_sample_cnt;

   logic       rdy_en = 1'b1;
   logic [7:0] commit_code = '0;
   logic [7:0] pwr_tab [256];
   logic [7:0] codes [$];
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 i_clk = ~i_clk;

   assign i_tune_rdy         = rdy_en;
   assign i_commit_val       = 1'b1;
   assign i_ring_tune_commit = commit_code;
   assign i_pwr_commit       = pwr_tab[commit_code];

   // Arbiter stand-in: record every issued code and echo it back at commit.
   always @(posedge i_clk) begin
      if (!i_rst && !i_search_abort && o_tune_val && i_tune_rdy) begin
         codes.push_back(o_ring_tune);
         commit_code <= o_ring_tune;
      end
   end

   tuner_ctrl_search #(.DAC_WIDTH(8), .ADC_WIDTH(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_search_start(i_search_start), .i_search_abort(i_search_abort),
      .i_cfg_code_start(i_cfg_code_start), .i_cfg_code_end(i_cfg_code_end),
      .i_cfg_code_step(i_cfg_code_step),
      .o_ctrl_active(o_ctrl_active), .o_ctrl_refresh(o_ctrl_refresh),
      .o_tune_val(o_tune_val), .i_tune_rdy(i_tune_rdy), .o_ring_tune(o_ring_tune),
      .i_commit_val(i_commit_val), .o_commit_rdy(o_commit_rdy),
      .i_pwr_commit(i_pwr_commit), .i_ring_tune_commit(i_ring_tune_commit),
      .o_search_done(o_search_done), .o_peak_pwr(o_peak_pwr),
      .o_peak_code(o_peak_code), .o_sample_cnt(o_sample_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic chk_zero_outs(input string tag);
      chk({tag, "_active"}, o_ctrl_active, 1'b0);
      chk({tag, "_refresh"}, o_ctrl_refresh, 1'b0);
      chk({tag, "_tval"}, o_tune_val, 1'b0);
      chk({tag, "_crdy"}, o_commit_rdy, 1'b0);
      chk({tag, "_done"}, o_search_done, 1'b0);
      chk({tag, "_ring"}, o_ring_tune, 8'h00);
      chk({tag, "_ppwr"}, o_peak_pwr, 8'h00);
      chk({tag, "_pcode"}, o_peak_code, 8'h00);
      chk({tag, "_cnt"}, o_sample_cnt, 9'h000);
   endtask

   // Pulse start for one cycle; returns at the negedge of the INIT cycle.
   task automatic do_start(input string tag, input logic [7:0] s, input logic [7:0] e,
                           input logic [7:0] st);
      @(negedge i_clk);
      codes.delete();
      i_cfg_code_start = s;
      i_cfg_code_end   = e;
      i_cfg_code_step  = st;
      i_search_start   = 1'b1;
      @(negedge i_clk);
      i_search_start = 1'b0;
      chk({tag, "_refresh"}, o_ctrl_refresh, 1'b1);
      chk({tag, "_active"}, o_ctrl_active, 1'b1);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200 && !o_search_done; i++) @(negedge i_clk);
      chk({tag, "_done"}, o_search_done, 1'b1);
   endtask

   task automatic chk_codes(input string tag, input int n, input logic [7:0] c0,
                            input logic [7:0] c1, input logic [7:0] c2);
      logic [7:0] exp [3];
      exp[0] = c0; exp[1] = c1; exp[2] = c2;
      chk({tag, "_ncodes"}, codes.size(), n);
      for (int i = 0; i < n && i < codes.size(); i++)
         chk($sformatf("%s_code%0d", tag, i), codes[i], exp[i]);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) pwr_tab[i] = '0;

      // Reset state
      repeat (3) @(negedge i_clk);
      chk_zero_outs("rst");
      i_rst = 1'b0;

      // Basic sweep: powers 5,9,7 at 0x10,0x12,0x14
      pwr_tab[8'h10] = 8'd5; pwr_tab[8'h12] = 8'd9; pwr_tab[8'h14] = 8'd7;
      do_start("sw1", 8'h10, 8'h14, 8'd2);
      @(negedge i_clk);
      chk("sw1_refresh_pulse", o_ctrl_refresh, 1'b0);
      wait_done("sw1");
      chk_codes("sw1", 3, 8'h10, 8'h12, 8'h14);
      chk("sw1_ppwr", o_peak_pwr, 8'd9);
      chk("sw1_pcode", o_peak_code, 8'h12);
      chk("sw1_cnt", o_sample_cnt, 9'd3);
      repeat (3) @(negedge i_clk);
      chk("sw1_hold_done", o_search_done, 1'b1);
      chk("sw1_hold_cnt", o_sample_cnt, 9'd3);

      // Overflow past the top code
      do_start("ovf", 8'hFC, 8'hFF, 8'd3);
      wait_done("ovf");
      chk_codes("ovf", 2, 8'hFC, 8'hFF, 8'h00);
      chk("ovf_cnt", o_sample_cnt, 9'd2);

      // start > end sweeps a single point
      do_start("rev", 8'h20, 8'h10, 8'd1);
      wait_done("rev");
      chk_codes("rev", 1, 8'h20, 8'h00, 8'h00);
      chk("rev_cnt", o_sample_cnt, 9'd1);

      // step 0 behaves as step 1
      do_start("st0", 8'h00, 8'h02, 8'd0);
      wait_done("st0");
      chk_codes("st0", 3, 8'h00, 8'h01, 8'h02);
      chk("st0_cnt", o_sample_cnt, 9'd3);

      // Tie keeps the earlier code
      pwr_tab[8'h00] = 8'd6; pwr_tab[8'h01] = 8'd6;
      do_start("tie", 8'h00, 8'h01, 8'd1);
      wait_done("tie");
      chk("tie_ppwr", o_peak_pwr, 8'd6);
      chk("tie_pcode", o_peak_code, 8'h00);

      // Backpressure stall; config changes mid-sweep are ignored
      rdy_en = 1'b0;
      do_start("stl", 8'h30, 8'h31, 8'd1);
      i_cfg_code_start = 8'h80; i_cfg_code_end = 8'h90; i_cfg_code_step = 8'd4;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         chk($sformatf("stl_tval%0d", i), o_tune_val, 1'b1);
         chk($sformatf("stl_ring%0d", i), o_ring_tune, 8'h30);
      end
      rdy_en = 1'b1;
      wait_done("stl");
      chk_codes("stl", 2, 8'h30, 8'h31, 8'h00);
      chk("stl_cnt", o_sample_cnt, 9'd2);

      // Abort on the commit-fire cycle of sample 2
      pwr_tab[8'h50] = 8'd3; pwr_tab[8'h51] = 8'd8;
      do_start("abt", 8'h50, 8'h60, 8'd1);
      for (int i = 0; i < 50 && !(o_commit_rdy && o_sample_cnt == 9'd1); i++) @(negedge i_clk);
      chk("abt_reach_commit2", o_commit_rdy, 1'b1);
      i_search_abort = 1'b1;
      @(negedge i_clk);
      i_search_abort = 1'b0;
      chk("abt_active", o_ctrl_active, 1'b0);
      chk("abt_tval", o_tune_val, 1'b0);
      chk("abt_crdy", o_commit_rdy, 1'b0);
      chk("abt_done", o_search_done, 1'b0);
      chk("abt_cnt", o_sample_cnt, 9'd1);
      chk("abt_ppwr", o_peak_pwr, 8'd3);
      chk("abt_pcode", o_peak_code, 8'h50);

      // Restart clears peak; stall in TUNE and ignore a start there
      rdy_en = 1'b0;
      do_start("rst2", 8'h50, 8'h60, 8'd1);
      @(negedge i_clk);
      chk("rst2_refresh_pulse", o_ctrl_refresh, 1'b0);
      chk("rst2_ppwr", o_peak_pwr, 8'd0);
      chk("rst2_pcode", o_peak_code, 8'd0);
      chk("rst2_cnt", o_sample_cnt, 9'd0);
      i_search_start = 1'b1;
      repeat (2) @(negedge i_clk);
      i_search_start = 1'b0;
      chk("ign_refresh", o_ctrl_refresh, 1'b0);
      chk("ign_tval", o_tune_val, 1'b1);
      chk("ign_ring", o_ring_tune, 8'h50);

      // Reset mid-sweep beats start and abort
      i_rst = 1'b1; i_search_start = 1'b1; i_search_abort = 1'b1;
      @(negedge i_clk);
      chk_zero_outs("midrst");
      i_rst = 1'b0; i_search_start = 1'b0; i_search_abort = 1'b0;
      rdy_en = 1'b1;
      @(negedge i_clk);
      chk("post_rst_idle", o_ctrl_active, 1'b0);
      chk("post_rst_done", o_search_done, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/tuner_ctrl_search.md
TUNER_CTRL_SEARCH -- requirements
Module: tuner_ctrl_search

Interface
REQ-001: Parameter DAC_WIDTH, default 8, ring-tuner DAC code width.
REQ-002: Parameter ADC_WIDTH, default 8, power-detect sample width.
REQ-003: i_clk  input  1  single clock; all logic on posedge.
REQ-004: i_rst  input  1  reset; synchronous, active-high.
REQ-005: i_search_start  input  1  start pulse; sampled in IDLE/DONE only.
REQ-006: i_search_abort  input  1  abort request; sampled in any state.
REQ-007: i_cfg_code_start  input  DAC_WIDTH  first code of the sweep.
REQ-008: i_cfg_code_end  input  DAC_WIDTH  last permitted code of the sweep.
REQ-009: i_cfg_code_step  input  DAC_WIDTH  code increment; 0 is treated as 1.
REQ-010: o_ctrl_active  output  1  high in INIT, TUNE and COMMIT; drives arbiter power-detect active.
REQ-011: o_ctrl_refresh  output  1  one-cycle pulse in INIT; drives arbiter refresh.
REQ-012: o_tune_val / i_tune_rdy / o_ring_tune  out/in/out  1/1/DAC_WIDTH  tune-code handshake to the arbiter.
REQ-013: i_commit_val / o_commit_rdy  in/out  1/1  commit handshake from the arbiter.
REQ-014: i_pwr_commit / i_ring_tune_commit  input  ADC_WIDTH/DAC_WIDTH  synchronized power and code from the arbiter.
REQ-015: o_search_done  output  1  level; high in DONE.
REQ-016: o_peak_pwr / o_peak_code  output  ADC_WIDTH/DAC_WIDTH  best power seen and its committed code.
REQ-017: o_sample_cnt  output  DAC_WIDTH+1  commits accepted in the current sweep.

Function
REQ-018: FSM states are IDLE, INIT, TUNE, COMMIT and DONE.
REQ-019: IDLE or DONE with i_search_start=1 SHALL go to INIT and latch start, end and step (step 0 becomes 1).
REQ-020: INIT SHALL last exactly one cycle: o_ctrl_refresh=1, code<=start, peak registers, valid flag and o_sample_cnt cleared; next state is TUNE.
REQ-021: TUNE SHALL hold o_tune_val=1 with o_ring_tune=current code, stable until fire (o_tune_val && i_tune_rdy); on fire go to COMMIT.
REQ-022: o_tune_val SHALL be 0 outside TUNE; o_ring_tune SHALL hold the last code outside TUNE.
REQ-023: COMMIT SHALL hold o_commit_rdy=1; on fire (i_commit_val && o_commit_rdy), o_sample_cnt increments.
REQ-024: On commit fire, if the valid flag is clear or i_pwr_commit > o_peak_pwr (strictly greater), peak SHALL load i_pwr_commit and i_ring_tune_commit and set the valid flag; ties keep the earlier code.
REQ-025: Next code SHALL be computed in DAC_WIDTH+1 bits as code+step; if the result exceeds latched end or 2^DAC_WIDTH-1, go to DONE, else code<=sum and go to TUNE, all on the commit-fire cycle.
REQ-026: If start > end, exactly one point (start) SHALL be swept and the FSM SHALL then go to DONE.
REQ-027: DONE SHALL hold o_search_done=1 and hold the peak outputs and o_sample_cnt until the next INIT.
REQ-028: i_search_start in INIT, TUNE or COMMIT SHALL be ignored.
REQ-029: i_search_abort=1 in any state SHALL force IDLE next cycle, with priority over start and all handshakes; a fire in the same cycle SHALL NOT update the peak or the counter.
REQ-030: Config input changes after INIT SHALL NOT affect the running sweep.

Reset
REQ-031: While i_rst=1 at a posedge, state SHALL become IDLE and every output SHALL be 0 (o_ring_tune, peaks, o_sample_cnt, val, rdy, active, refresh, done), including mid-sweep.
REQ-032: Reset SHALL take priority over abort and start.

Verification
REQ-033: start=0x10, end=0x14, step=2, arbiter with rdy always 1, pwr = {5,9,7} -> codes 0x10,0x12,0x14 issued; DONE with peak_pwr=9, peak_code=0x12, sample_cnt=3.
REQ-034: start=0xFC, end=0xFF, step=3 -> codes 0xFC,0xFF only; the overflow path ends in DONE with sample_cnt=2.
REQ-035: start=0x20, end=0x10 -> single code 0x20 and sample_cnt=1; step=0 with start=0, end=2 -> codes 0,1,2.
REQ-036: Equal powers {6,6} at codes 0,1 -> peak_code=0; i_tune_rdy held low for 5 cycles -> o_tune_val and o_ring_tune stay stable.
REQ-037: Abort asserted on the commit-fire cycle of sample 2 -> next cycle IDLE, sample_cnt still 1, val=rdy=0; a restart gives a one-cycle refresh pulse and clears the peak.
REQ-038: i_rst asserted while in TUNE -> next cycle all outputs 0 and state IDLE; start asserted during the sweep -> ignored.
